// File: rtl/bbs_sequencer.sv
// -----------------------------------------------------------------------------
// bbs_sequencer
//
// Blum Blum Shub bit generator. A range-checked seed is loaded into the state
// register x, then x <- x^2 mod MOD is iterated through one mod_multiplier
// instance. The LSB of each new state is shifted into a word; every OUT_BITS
// bits the word is presented on a valid/ready output handshake.
//
// Parameters: SIZE is the state / seed width, the modulus parameter is the
// Blum modulus (default 179*227), and OUT_BITS is the number of bits per
// output word (2..SIZE).
//
// Ports
//   clk        single clock, posedge
//   reset      asynchronous active-low reset
//   seed_in    seed value, sampled when seed_load=1
//   seed_load  load request
//   out_ready  consumer accepts the held word
//   out_valid  out_data holds a completed word
//   out_data   packed bits, first-generated bit in MSB
//   busy       high while squaring or capturing
//   seed_err   one-cycle pulse for a rejected seed
//   state_out  current BBS state x
// -----------------------------------------------------------------------------

// Registered modular squarer: out <= x^2 mod MOD on every clock edge.
//   clk    clock
//   reset  synchronous active-high clear
//   x      operand
//   out    registered square modulo MOD
module mod_multiplier #(
    parameter int unsigned SIZE = 16,
    parameter int unsigned MOD  = 40633
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] x,
    output logic [SIZE-1:0] out
);
    localparam logic [2*SIZE-1:0] MOD_W = (2*SIZE)'(MOD);

    logic [2*SIZE-1:0] square;
    logic [SIZE-1:0]   out_d;
    logic [SIZE-1:0]   out_q;

    always_comb begin
        square = {{SIZE{1'b0}}, x} * {{SIZE{1'b0}}, x};
        out_d  = SIZE'(square % MOD_W);
    end

    // NOTE: this register uses a synchronous clear, so it only clears on a
    // clock edge while reset is held; the sequencer never reads it outside
    // CAPTURE, so a stale value after an asynchronous reset is harmless.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples the pre-edge values of its inputs.
        if (reset) out_q <= '0;
        else       out_q <= out_d;
    end

    assign out = out_q;
endmodule

module bbs_sequencer #(
    parameter int unsigned SIZE     = 16,
    parameter int unsigned MOD      = 40633,
    parameter int unsigned OUT_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SIZE-1:0]     seed_in,
    input  logic                seed_load,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data,
    output logic                busy,
    output logic                seed_err,
    output logic [SIZE-1:0]     state_out
);
    localparam int unsigned     CW       = $clog2(OUT_BITS) + 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(OUT_BITS - 1);
    // Seeds 0, 1 and MOD-1 collapse to a fixed point; MOD and above are
    // out of range.
    localparam logic [SIZE-1:0] SEED_MIN = SIZE'(2);
    localparam logic [SIZE-1:0] SEED_MAX = SIZE'(MOD - 2);

    typedef enum logic [1:0] {
        IDLE,
        SQUARE,
        CAPTURE,
        HOLD
    } fsm_e;

    fsm_e                fsm_q, fsm_d;
    logic [SIZE-1:0]     x_q, x_d;
    logic [CW-1:0]       count_q, count_d;
    logic [OUT_BITS-1:0] shift_q, shift_d;
    logic [OUT_BITS-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                seed_err_q, seed_err_d;

    logic [SIZE-1:0]     mult_out;
    logic [OUT_BITS-1:0] shift_next;
    logic                seed_ok;
    logic                load_ok;
    logic                last_bit;

    mod_multiplier #(
        .SIZE (SIZE),
        .MOD  (MOD)
    ) u_mult (
        .clk   (clk),
        .reset (~reset),
        .x     (x_q),
        .out   (mult_out)
    );

    assign seed_ok    = (seed_in >= SEED_MIN) && (seed_in <= SEED_MAX);
    assign load_ok    = seed_load && seed_ok;
    assign last_bit   = (count_q == LAST_CNT);
    assign shift_next = {shift_q[OUT_BITS-2:0], mult_out[0]};

    // State register (FSM and datapath).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q       <= IDLE;
            x_q         <= '0;
            count_q     <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            seed_err_q  <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            x_q         <= x_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            seed_err_q  <= seed_err_d;
        end
    end

    // Next-state logic. A valid load overrides every state, including HOLD
    // with out_ready high: the held word is dropped.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:    fsm_d = IDLE;
            SQUARE:  fsm_d = CAPTURE;
            CAPTURE: fsm_d = last_bit ? HOLD : SQUARE;
            HOLD:    fsm_d = out_ready ? SQUARE : HOLD;
            default: fsm_d = IDLE;
        endcase
        if (load_ok) fsm_d = SQUARE;
    end

    // Datapath next values and outputs.
    always_comb begin
        x_d         = x_q;
        count_d     = count_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        seed_err_d  = seed_load && !seed_ok;

        if (load_ok) begin
            x_d         = seed_in;
            count_d     = '0;
            shift_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            case (fsm_q)
                CAPTURE: begin
                    x_d     = mult_out;
                    shift_d = shift_next;
                    if (last_bit) begin
                        count_d     = '0;
                        out_data_d  = shift_next;
                        out_valid_d = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) out_valid_d = 1'b0;
                end
                default: ;
            endcase
        end

        busy      = (fsm_q == SQUARE) || (fsm_q == CAPTURE);
        out_valid = out_valid_q;
        out_data  = out_data_q;
        seed_err  = seed_err_q;
        state_out = x_q;
    end
endmodule

// File: tb/tb_bbs_sequencer.sv
module tb_bbs_sequencer;
    localparam int unsigned SIZE     = 16;
    localparam int unsigned MOD      = 40633;
    localparam int unsigned OUT_BITS = 8;

    logic                clk;
    logic                reset;
    logic [SIZE-1:0]     seed_in;
    logic                seed_load;
    logic                out_ready;
    logic                out_valid;
    logic [OUT_BITS-1:0] out_data;
    logic                busy;
    logic                seed_err;
    logic [SIZE-1:0]     state_out;

    int checks   = 0;
    int failures = 0;

    bbs_sequencer #(
        .SIZE     (SIZE),
        .MOD      (MOD),
        .OUT_BITS (OUT_BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .seed_in   (seed_in),
        .seed_load (seed_load),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .seed_err  (seed_err),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One clock edge, then settle 1 ns past it for driving and sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        seed_load = 1'b0;
        seed_in   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Returns 1 ns after the sampling edge, with seed_load already dropped.
    task automatic load_seed(input logic [SIZE-1:0] v);
        seed_in   = v;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, output int n);
        n = 0;
        while (!out_valid && n < max_cycles) begin
            tick();
            n++;
        end
    endtask

    // Reference BBS model: one squaring step and one packed word.
    function automatic logic [SIZE-1:0] bbs_step(input logic [SIZE-1:0] x);
        longint unsigned p;
        p = longint'(x) * longint'(x);
        return SIZE'(p % MOD);
    endfunction

    function automatic logic [OUT_BITS-1:0] model_word(input logic [SIZE-1:0] x_in,
                                                      output logic [SIZE-1:0] x_out);
        logic [SIZE-1:0]     x;
        logic [OUT_BITS-1:0] w;
        x = x_in;
        w = '0;
        for (int i = 0; i < OUT_BITS; i++) begin
            x = bbs_step(x);
            w = {w[OUT_BITS-2:0], x[0]};
        end
        x_out = x;
        return w;
    endfunction

    typedef struct {
        logic [SIZE-1:0] seed;
        logic            exp_err;
        logic [SIZE-1:0] exp_state;
        logic            exp_busy;
    } seed_vec_t;

    seed_vec_t vecs[6];

    initial begin
        logic [SIZE-1:0]     xm;
        logic [OUT_BITS-1:0] w1, w2, w200, held_data;
        logic [SIZE-1:0]     held_state;
        int                  n;
        logic                bad;

        // seed, seed_err expected, state_out after the load edge, busy expected
        vecs[0] = '{16'd0,     1'b1, 16'd0, 1'b0};
        vecs[1] = '{16'd1,     1'b1, 16'd0, 1'b0};
        vecs[2] = '{16'd40632, 1'b1, 16'd0, 1'b0};
        vecs[3] = '{16'd40633, 1'b1, 16'd0, 1'b0};
        vecs[4] = '{16'd65535, 1'b1, 16'd0, 1'b0};
        vecs[5] = '{16'd2,     1'b0, 16'd2, 1'b1};

        // ---------------- reset then idle ----------------
        do_reset();
        for (int c = 0; c < 20; c++) begin
            check("idle_outputs_zero", {out_valid, busy, seed_err, out_data, state_out}, 0);
            tick();
        end

        // ---------------- seed range check (table) ----------------
        for (int i = 0; i < 6; i++) begin
            load_seed(vecs[i].seed);
            check($sformatf("seed_err[%0d]", vecs[i].seed), seed_err, vecs[i].exp_err);
            check($sformatf("state_after_load[%0d]", vecs[i].seed), state_out, vecs[i].exp_state);
            check($sformatf("busy_after_load[%0d]", vecs[i].seed), busy, vecs[i].exp_busy);
            tick();
            check($sformatf("seed_err_clears[%0d]", vecs[i].seed), seed_err, 0);
        end
        // Seed 2 is now one edge past its load edge (SQUARE -> CAPTURE).
        tick();
        check("seed2_state1", state_out, 4);
        tick(); tick();
        check("seed2_state2", state_out, 16);
        tick(); tick();
        check("seed2_state3", state_out, 256);

        // ---------------- seed 200, continuous output ----------------
        do_reset();
        out_ready = 1'b1;
        w1  = model_word(16'd200, xm);
        w2  = model_word(xm, xm);
        bad = 1'b0;
        load_seed(16'd200);
        for (int c = 1; c <= 33; c++) begin
            tick();
            if (c == 1)  check("s200_busy", busy, 1);
            if (c == 2)  check("s200_state1", state_out, 40000);
            if (c == 4)  check("s200_state2", state_out, 34992);
            if (c == 6)  check("s200_state3", state_out, 5242);
            if (c == 16) begin
                check("s200_valid_at_16", out_valid, 1);
                check("s200_word1", out_data, w1);
                check("s200_msbs", out_data[OUT_BITS-1:OUT_BITS-3], 0);
                check("s200_busy_in_hold", busy, 0);
            end else if (c == 17) begin
                check("s200_valid_drops", out_valid, 0);
            end else if (c == 33) begin
                check("s200_valid_at_33", out_valid, 1);
                check("s200_word2", out_data, w2);
            end else if (out_valid) begin
                bad = 1'b1;
            end
        end
        check("s200_no_stray_valid", bad, 0);
        w200 = w1;

        // ---------------- backpressure ----------------
        do_reset();
        w1 = model_word(16'd884, xm);
        w2 = model_word(xm, xm);
        load_seed(16'd884);
        wait_valid(40, n);
        check("bp_first_latency", n, 16);
        check("bp_word1", out_data, w1);
        held_data  = out_data;
        held_state = state_out;
        bad = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (!out_valid || out_data !== held_data || state_out !== held_state) bad = 1'b1;
        end
        check("bp_hold_stable", bad, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_valid_drops", out_valid, 0);
        wait_valid(40, n);
        check("bp_next_latency", n, 16);
        check("bp_word2", out_data, w2);

        // ---------------- reload mid-word ----------------
        do_reset();
        out_ready = 1'b1;
        load_seed(16'd13089);
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (out_valid) bad = 1'b1;
        end
        load_seed(16'd200);
        check("reload_state", state_out, 200);
        wait_valid(40, n);
        check("reload_latency", n, 16);
        check("reload_word", out_data, w200);
        check("reload_no_early_word", bad, 0);

        // ---------------- async reset mid-word ----------------
        out_ready = 1'b1;
        load_seed(16'd200);
        for (int c = 0; c < 5; c++) tick();
        check("arst_busy_before", busy, 1);
        check("arst_state_before", state_out, 34992);
        #3;
        reset = 1'b0;
        #1;
        check("arst_outputs_immediate", {out_valid, busy, seed_err, out_data, state_out}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (busy || out_valid || state_out != 0) bad = 1'b1;
        end
        check("arst_idle_after_release", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bbs_sequencer.md
# bbs_sequencer

Controller that sequences the `mod_multiplier` squaring datapath as a Blum Blum Shub bit generator. It accepts a seed, checks it for range, and iterates x ← x² mod MOD through one `mod_multiplier` instance. It takes the LSB of each new state and packs OUT_BITS of them into a word. Completed words leave through a valid/ready output handshake.

## Interface
- SIZE, 16: state/seed width; passed to `mod_multiplier`.
- MOD, 40633: Blum modulus (179·227); passed to `mod_multiplier`.
- OUT_BITS, 8: bits per output word, 2..SIZE.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- seed_in  in  SIZE  seed value, sampled only when seed_load=1.
- seed_load  in  1  load request, sampled at posedge.
- out_ready  in  1  consumer accepts the word.
- out_valid  out  1  out_data holds a completed word.
- out_data  out  OUT_BITS  packed random bits, first-generated bit in MSB.
- busy  out  1  high in SQUARE or CAPTURE.
- seed_err  out  1  one-cycle pulse: rejected seed.
- state_out  out  SIZE  current BBS state x (debug/verification).

## Operation
- Internal `mod_multiplier` instance: x = state register; its active-high sync reset port is driven with ~reset; its out is read only in CAPTURE.
- Seed valid iff 2 ≤ seed_in ≤ MOD-2. This excludes the fixed points 0 and 1, MOD-1 (which squares to 1), and out-of-range values.
- FSM states: IDLE (unseeded), SQUARE, CAPTURE, HOLD.
- Valid seed_load, in any state: state ← seed_in, bit count ← 0, shift reg ← 0, out_valid ← 0, FSM → SQUARE. Any partial or held word is discarded.
- Invalid seed_load: seed_err=1 for one cycle; state, FSM and outputs unchanged.
- SQUARE: the multiplier registers x² mod MOD at the closing edge. FSM → CAPTURE.
- CAPTURE: state ← mult out; shift ← {shift[OUT_BITS-2:0], mult out[0]}; count++.
  - If count was OUT_BITS-1: out_data ← new shift value, out_valid ← 1, count ← 0, FSM → HOLD.
  - Otherwise: FSM → SQUARE.
- HOLD: out_data and state are frozen.
  - out_valid & out_ready: out_valid ← 0, FSM → SQUARE at the next edge.
  - No out_ready: stay in HOLD indefinitely.
- out_ready is ignored while out_valid=0.
- IDLE is left only by a valid seed_load. There is no other start input; generation is continuous once seeded, throttled by out_ready.
- Arithmetic: all state values are < MOD and fit in SIZE bits. The multiplier is the only arithmetic; the controller does comparisons, shifting and counting only (count width ⌈log2 OUT_BITS⌉+1).

## Timing
- Reset values: out_valid 0, out_data 0, busy 0, seed_err 0, state_out 0, FSM IDLE. Reset applies asynchronously at assertion, mid-word included; the multiplier clears on the next clock.
- Each generated bit costs 2 cycles (SQUARE + CAPTURE).
- First word latency: out_valid rises 2·OUT_BITS cycles after the seed_load edge (16 for the default OUT_BITS).
- Back-to-back words with out_ready held 1: out_valid high for 1 cycle every 2·OUT_BITS+1 cycles.
- seed_err is asserted in the cycle after the sampling edge and deasserts the cycle after that.
- Simultaneous valid seed_load and out_ready in HOLD: seed_load wins; the held word is dropped and not counted as transferred.
- state_out changes only on load or in CAPTURE.

## Test plan
- Reset then idle: hold reset=0 for 3 cycles, release, run 20 cycles. Required: all outputs 0, FSM stays IDLE, out_valid never rises.
- Seed 200, out_ready=1: state_out sequence 40000, 34992, 5242 at CAPTURE edges 1-3. out_valid rises exactly 16 cycles after load with out_data equal to the bit-serial model (first three MSBs 000).
- Seed rejection: seed_in = 0, 1, 40632, 40633 each give a one-cycle seed_err with no state change. seed_in = 2 gives no seed_err, then state_out = 4, 16, 256.
- Backpressure: seed 884, out_ready=0 for 50 cycles. out_valid stays 1 and out_data/state_out stay stable. Raise out_ready for 1 cycle: out_valid drops and the next word arrives 16 cycles later.
- Reload mid-word: seed 13089, after 5 cycles load 200. Required: the following word is identical to the fresh seed-200 word, and no word is produced from 13089.
- Async reset mid-word: assert reset between clock edges during CAPTURE. Outputs are 0 immediately, before the next edge, and FSM is IDLE after release.
